// File: rtl/tx_ctrl_defs_pkg.sv
// Shared TX control definitions: FSM state encodings and default counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Reused by tx_frame_ctrl and later TX schedulers.
package tx_ctrl_defs_pkg;

  // Default widths for the frame length / symbol counter and the guard-gap counter.
  localparam int unsigned DEF_LEN_W = 16;
  localparam int unsigned DEF_GAP_W = 8;

  // Encodings are fixed so that other schedulers and debug tooling agree on them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  // True when a state owns the stream (i.e. the frame is in progress or in its gap).
  function automatic logic state_is_busy(input tx_state_e st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/gap_down_counter.sv
// Loadable down-counter for the inter-frame guard gap, with a zero flag.
// Latency: load/decrement take effect at the next clk edge; zero_o is registered-state derived.
// Backpressure: none; decrement saturates at zero.
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset (count clears to 0)
//   load_i      load load_val_i on the next edge (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one on the next edge (held at zero once reached)
//   cnt_o       current count
//   zero_o      count is zero
module gap_down_counter
  import tx_ctrl_defs_pkg::*;
#(
  parameter int unsigned GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [GAP_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [GAP_W-1:0] cnt_q;
  logic [GAP_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tx_frame_ctrl.sv
// Frame sequencer gating the bit-source -> QPSK modulator handshake: admits cfg_len
//   symbols per started frame, then holds an idle guard gap of cfg_gap cycles.
// Latency: zero-latency combinational pass-through in RUN, no storage; status pulses are registered (1 cycle).
// Backpressure: src_ready mirrors tx_ready in RUN; outside RUN both tx_valid and src_ready are held low.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, abort              frame start request (IDLE only), terminate frame/gap
//   cfg_len, cfg_gap          frame length / guard gap, latched on an accepted start
//   src_valid/src_i/src_q     bit-source stream in;   src_ready back-pressure out
//   tx_valid/tx_i/tx_q        modulator stream out;   tx_ready in
//   busy                      state is not IDLE
//   done, aborted, cfg_err    one-cycle status pulses
//   sof, eof                  first/last symbol qualifiers (valid with tx_valid)
//   sym_cnt                   symbols transferred in the current frame
module tx_frame_ctrl
  import tx_ctrl_defs_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             src_valid,
  input  logic             src_i,
  input  logic             src_q,
  output logic             src_ready,
  output logic             tx_valid,
  output logic             tx_i,
  output logic             tx_q,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic             sof,
  output logic             eof,
  output logic [LEN_W-1:0] sym_cnt
);

  tx_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             cfg_err_q, cfg_err_d;

  logic             gap_load;
  logic             gap_dec;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_zero;

  logic             run;
  logic             hs;
  logic             last_sym;
  logic             gap_last;

  // ---------------------------------------------------------------------------
  // Handshake gating. tx_valid is derived from src_valid and state only, never
  // from tx_ready, so the modulator sees a well-formed valid/ready source.
  // ---------------------------------------------------------------------------
  assign run       = (state_q == ST_RUN);
  assign tx_valid  = run & src_valid;
  assign src_ready = run & tx_ready;
  assign tx_i      = src_i;
  assign tx_q      = src_q;
  assign hs        = tx_valid & tx_ready;

  // len_q is never zero while in RUN (zero-length starts are rejected), so
  // len_q - 1 cannot underflow where it matters.
  assign last_sym  = (sym_cnt_q == (len_q - 1'b1));
  assign sof       = tx_valid & (sym_cnt_q == '0);
  assign eof       = tx_valid & last_sym;

  // The counter is loaded with the full gap on entry and decremented every GAP
  // cycle; leaving when it reads 1 gives exactly cfg_gap cycles in GAP. The
  // zero check only guards against ever getting stuck in GAP.
  assign gap_last  = (gap_cnt == GAP_W'(1)) | gap_zero;

  // ---------------------------------------------------------------------------
  // Next-state / status logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    gap_d     = gap_q;
    sym_cnt_d = sym_cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cfg_err_d = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort has no meaning here and is ignored.
        if (start) begin
          if (cfg_len != '0) begin
            len_d     = cfg_len;
            gap_d     = cfg_gap;
            sym_cnt_d = '0;
            state_d   = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          // A handshake in this cycle still happens on the wire, but it is
          // dropped from status: no count, no done even if it was the last.
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          sym_cnt_d = '0;
        end else if (hs) begin
          sym_cnt_d = sym_cnt_q + 1'b1;
          if (last_sym) begin
            done_d = 1'b1;
            if (gap_q != '0) begin
              gap_load = 1'b1;
              state_d  = ST_GAP;
            end else begin
              state_d  = ST_IDLE;
            end
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          sym_cnt_d = '0;
        end else begin
          gap_dec = 1'b1;
          if (gap_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      gap_q     <= '0;
      sym_cnt_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      sym_cnt_q <= sym_cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  gap_down_counter #(
    .GAP_W (GAP_W)
  ) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load),
    .load_val_i (gap_q),
    .dec_i      (gap_dec),
    .cnt_o      (gap_cnt),
    .zero_o     (gap_zero)
  );

  assign busy    = state_is_busy(state_q);
  assign done    = done_q;
  assign aborted = aborted_q;
  assign cfg_err = cfg_err_q;
  assign sym_cnt = sym_cnt_q;

  // A frame ends either by completion or by abort, never both.
  a_done_xor_abort : assert property (@(posedge clk) disable iff (rst) !(done && aborted));
  // The stream can only be open while a frame is running.
  a_valid_only_busy : assert property (@(posedge clk) disable iff (rst) !(tx_valid && !busy));

endmodule

// File: doc/tx_frame_ctrl.md
# tx_frame_ctrl

Frame-level sequencer in front of the TX path's QPSK modulator input. It admits exactly `cfg_len` I/Q bit-pairs from the bit source per started frame and then enforces an idle guard gap of `cfg_gap` cycles. It reports busy/done/abort status and marks the first and last symbol of each frame. It only gates the valid/ready handshake; data passes through unmodified.

## Interface
- `LEN_W`, 16: width of the frame length and symbol counter.
- `GAP_W`, 8: width of the guard-gap counter.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame start request; sampled only in IDLE.
- `abort`  in  1  terminate the current frame or gap.
- `cfg_len`  in  LEN_W  symbols per frame; latched on accepted start.
- `cfg_gap`  in  GAP_W  guard cycles after the frame; latched on accepted start.
- `src_valid`, `src_i`, `src_q`  in  1,1,1  bit-source stream.
- `src_ready`  out  1  back-pressure to the source.
- `tx_valid`, `tx_i`, `tx_q`  out  1,1,1  stream to the modulator.
- `tx_ready`  in  1  modulator ready.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse: frame completed.
- `aborted`  out  1  one-cycle pulse: frame/gap aborted.
- `cfg_err`  out  1  one-cycle pulse: start rejected because `cfg_len` == 0.
- `sof`, `eof`  out  1,1  first/last symbol qualifiers, meaningful when `tx_valid`.
- `sym_cnt`  out  LEN_W  symbols transferred in the current frame.

## Operation
- States are IDLE, RUN and GAP. Reset enters IDLE.
- **IDLE**
  - `start` with `cfg_len` ≠ 0: latch len/gap, clear `sym_cnt`, go to RUN.
  - `start` with `cfg_len` = 0: pulse `cfg_err`, stay in IDLE.
  - `abort` is ignored.
- **RUN** (combinational pass-through)
  - `tx_valid = src_valid`, `src_ready = tx_ready`, `tx_i/q = src_i/q`.
  - Each handshake (`tx_valid & tx_ready`) increments `sym_cnt`.
  - `sof` = (`sym_cnt` == 0); `eof` = (`sym_cnt` == len−1).
  - Handshake with `eof` set: pulse `done` next cycle. Go to GAP if gap ≠ 0, else to IDLE.
- **Outside RUN:** `tx_valid` = 0 and `src_ready` = 0, regardless of the source.
- **GAP**
  - The down-counter is loaded with gap on entry.
  - It decrements every cycle and exits to IDLE after exactly gap cycles in GAP.
- **`abort` in RUN or GAP:** next state IDLE, pulse `aborted`, no `done`.
  - A handshake in the same cycle still completes, since it is combinational.
  - That handshake is discarded from status: `sym_cnt` clears and `done` is suppressed even if it carried `eof`.
- **`start` while busy:** ignored, no error.
- **`cfg_len`/`cfg_gap` changes:** changes after acceptance have no effect on the running frame.

## Timing
- **Reset values:**
  - `busy`, `done`, `aborted`, `cfg_err`, `tx_valid`, `src_ready`: 0.
  - `sym_cnt`: 0. `sof`: 0, since `tx_valid` = 0. `eof`: 0.
- **Start to first transfer:** `start` accepted at edge k; RUN from k+1. The first transfer can occur in cycle k+1.
- **Frame end:** last handshake at edge m. At m+1, `done` = 1 and the state is GAP (or IDLE).
- **Back-to-back frames:**
  - gap = 0: IDLE at m+1, so `start` can be accepted at m+1 (same cycle as `done`).
  - gap = G: IDLE at m+1+G.
- **Pulse width:** `done`, `aborted` and `cfg_err` are registered and exactly one cycle wide.
- **Handshake latency:** the pass-through adds zero latency and no storage. `tx_valid` never depends on `tx_ready`.
- **Counter widths:**
  - `sym_cnt` never wraps; the maximum frame is 2^LEN_W−1 symbols.
  - The gap counter is GAP_W bits wide; the maximum gap is 2^GAP_W−1.
- **`rst` mid-frame:** asynchronous return to IDLE; all outputs go to their reset values immediately, with no `done`/`aborted` pulse.

## Structure
- Shared defines file `tx_ctrl_defs`: state encodings (IDLE=0, RUN=1, GAP=2) and the default LEN_W/GAP_W. It is reused by later TX schedulers.
- One sub-module, `gap_down_counter`: loadable, GAP_W-wide, async active-high reset, with a `zero` flag.
- The FSM, symbol counter and handshake gating stay in `tx_frame_ctrl`.

## Test plan
- **Basic frame:** len=4, gap=3, source always valid, `tx_ready`=1.
  - Exactly 4 transfers; `sof` on the first, `eof` on the 4th.
  - `done` one cycle after the 4th transfer.
  - `busy` falls 3 cycles later.
- **Back-pressure:** len=5, `tx_ready` toggling 1/0.
  - `src_ready` mirrors `tx_ready`.
  - `sym_cnt` advances only on handshakes and reaches 5 before `done`.
- **Zero gap, back-to-back:** len=2, gap=0, `start` held high.
  - The second frame starts in the cycle `done` is high, giving 4 transfers with no idle cycle except the start cycle.
- **Rejects:**
  - `start` with len=0: `cfg_err` pulse, `busy` stays 0.
  - `start` during RUN: ignored; the frame length is unchanged.
- **Abort:** len=10, `abort` after 3 transfers.
  - `aborted` pulse, IDLE next cycle, `tx_valid`=0, `sym_cnt`=0, no `done`.
  - Repeat with `abort` coincident with the `eof` handshake: no `done`.
- **Async reset mid-GAP:** all outputs go to reset values without a clock edge; a subsequent `start` works normally.
